// File: rtl/adc_serial_capture.sv
// Serial ADC frame capture: generates CS_n/SCLK from clk_100MHz, deserialises
// MSB-first frames and presents each sample with a one-cycle valid strobe.
module adc_serial_capture #(
  parameter int CLK_DIV    = 5,
  parameter int FRAME_BITS = 16,
  parameter int LEAD_BITS  = 4,
  parameter int DATA_BITS  = 12,
  parameter int QUIET_CYC  = 4
) (
  input  logic                 clk_100MHz,
  input  logic                 Rst_n,
  input  logic                 ADC_En,
  input  logic                 ADC_Dout,
  output logic                 ADC_Sclk,
  output logic                 ADC_Cs_n,
  output logic [DATA_BITS-1:0] ADC_Data,
  output logic                 ADC_Valid,
  output logic                 ADC_Frame_Err,
  output logic [15:0]          Sample_Cnt
);

  localparam int CNT_MAX = (2*CLK_DIV > QUIET_CYC) ? 2*CLK_DIV : QUIET_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF       = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] PER_LAST   = CNT_W'(2*CLK_DIV - 1);
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, QUIET} state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [BIT_W-1:0]      bit_idx, bit_idx_n;
  logic                  stop_req, stop_req_n;
  logic [FRAME_BITS-1:0] shreg;

  logic setup_done, period_done, frame_done, quiet_done, sample_pt;
  logic sclk_d, cs_n_d;

  assign setup_done  = (state == CS_SETUP) && (cnt == DIV_LAST);
  assign period_done = (state == SHIFT) && (cnt == PER_LAST);
  assign frame_done  = period_done && (bit_idx == BIT_LAST);
  assign quiet_done  = (state == QUIET) && (cnt == QUIET_LAST);
  // Sampling edge is the one on which SCLK is driven 0->1.
  assign sample_pt   = (state == SHIFT) && (cnt == DIV_LAST);

  always_ff @(posedge clk_100MHz or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_req <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      stop_req <= stop_req_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt + CNT_W'(1);
    bit_idx_n  = bit_idx;
    stop_req_n = stop_req;
    case (state)
      IDLE: begin
        cnt_n      = '0;
        bit_idx_n  = '0;
        stop_req_n = 1'b0;
        if (ADC_En) state_n = CS_SETUP;
      end
      CS_SETUP: begin
        if (!ADC_En) stop_req_n = 1'b1;
        if (setup_done) begin
          state_n   = SHIFT;
          cnt_n     = '0;
          bit_idx_n = '0;
        end
      end
      SHIFT: begin
        if (!ADC_En) stop_req_n = 1'b1;
        if (period_done) begin
          cnt_n = '0;
          if (bit_idx == BIT_LAST) state_n = QUIET;
          else bit_idx_n = bit_idx + BIT_W'(1);
        end
      end
      QUIET: begin
        if (quiet_done) begin
          cnt_n      = '0;
          stop_req_n = 1'b0;
          state_n    = (ADC_En && !stop_req) ? CS_SETUP : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Pins are derived from the next state so the registered outputs line up
  // with the state register rather than lagging it by a cycle.
  always_comb begin
    sclk_d = 1'b1;
    cs_n_d = 1'b1;
    if (state_n == CS_SETUP) cs_n_d = 1'b0;
    if (state_n == SHIFT) begin
      cs_n_d = 1'b0;
      sclk_d = (cnt_n >= HALF);
    end
  end

  always_ff @(posedge clk_100MHz or negedge Rst_n) begin
    if (!Rst_n) begin
      ADC_Sclk      <= 1'b1;
      ADC_Cs_n      <= 1'b1;
      ADC_Valid     <= 1'b0;
      ADC_Data      <= '0;
      ADC_Frame_Err <= 1'b0;
      Sample_Cnt    <= '0;
      shreg         <= '0;
    end else begin
      ADC_Sclk  <= sclk_d;
      ADC_Cs_n  <= cs_n_d;
      ADC_Valid <= frame_done;
      if (sample_pt) shreg <= {shreg[FRAME_BITS-2:0], ADC_Dout};
      if (frame_done) begin
        ADC_Data      <= shreg[FRAME_BITS-1-LEAD_BITS -: DATA_BITS];
        ADC_Frame_Err <= |shreg[FRAME_BITS-1 -: LEAD_BITS];
        Sample_Cnt    <= Sample_Cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_adc_serial_capture.sv
// Directed/randomised bench for adc_serial_capture with a behavioural ADC model.
module tb_adc_serial_capture;

  localparam int FRAME_CYC = 169;
  localparam int CS_LOW    = 165;

  logic        clk_100MHz = 1'b0;
  logic        Rst_n      = 1'b0;
  logic        ADC_En     = 1'b0;
  logic        ADC_Dout   = 1'b0;
  logic        ADC_Sclk, ADC_Cs_n, ADC_Valid, ADC_Frame_Err;
  logic [11:0] ADC_Data;
  logic [15:0] Sample_Cnt;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  logic [15:0] tx_q[$];
  logic [15:0] cur_word = '0;
  int          bitpos   = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  adc_serial_capture #(
    .CLK_DIV(5), .FRAME_BITS(16), .LEAD_BITS(4), .DATA_BITS(12), .QUIET_CYC(4)
  ) dut (
    .clk_100MHz(clk_100MHz), .Rst_n(Rst_n), .ADC_En(ADC_En), .ADC_Dout(ADC_Dout),
    .ADC_Sclk(ADC_Sclk), .ADC_Cs_n(ADC_Cs_n), .ADC_Data(ADC_Data),
    .ADC_Valid(ADC_Valid), .ADC_Frame_Err(ADC_Frame_Err), .Sample_Cnt(Sample_Cnt)
  );

  // ADC model: CS_n falling (SCLK high) loads the next word; every SCLK
  // falling edge presents the next bit MSB-first, junk once the word is spent.
  always @(negedge ADC_Cs_n or negedge ADC_Sclk) begin
    if (ADC_Sclk === 1'b1) begin
      cur_word = (tx_q.size() > 0) ? tx_q.pop_front() : 16'h0000;
      bitpos   = 0;
      ADC_Dout = 1'($urandom_range(0, 1));
    end else if (ADC_Cs_n === 1'b0) begin
      if (bitpos < 16) ADC_Dout = cur_word[15 - bitpos];
      else ADC_Dout = 1'($urandom_range(0, 1));
      bitpos++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int cyc, output int cs_low,
                            output int rises, output bit ok);
    logic prev;
    prev = ADC_Sclk; cyc = 0; cs_low = 0; rises = 0; ok = 1'b0;
    while (cyc < budget) begin
      @(negedge clk_100MHz);
      cyc++;
      if (!ADC_Cs_n) cs_low++;
      if (!prev && ADC_Sclk) rises++;
      prev = ADC_Sclk;
      if (ADC_Valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rises(input int n, input int budget, output bit ok);
    logic prev;
    int r, c;
    prev = ADC_Sclk; r = 0; c = 0; ok = 1'b0;
    while (c < budget) begin
      @(negedge clk_100MHz);
      c++;
      if (!prev && ADC_Sclk) r++;
      prev = ADC_Sclk;
      if (r == n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic idle_watch(input string tag, input int ncyc);
    int bad;
    bad = 0;
    repeat (ncyc) begin
      @(negedge clk_100MHz);
      if (!ADC_Cs_n || !ADC_Sclk || ADC_Valid) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic check_sample(input string tag, input logic [15:0] w);
    exp_cnt = (exp_cnt + 1) % 65536;
    chk({tag, "_data"}, 32'(ADC_Data), 32'(w % 16'h1000));
    chk({tag, "_err"}, 32'(ADC_Frame_Err), 32'((w >> 12) != 0));
    chk({tag, "_cnt"}, 32'(Sample_Cnt), exp_cnt);
  endtask

  task automatic run_single(input string tag, input logic [15:0] w);
    int cyc, cs_low, rises;
    bit ok;
    tx_q.push_back(w);
    ADC_En = 1'b1;
    @(negedge clk_100MHz);
    chk({tag, "_cs_start"}, 32'(ADC_Cs_n), 0);
    ADC_En = 1'b0;
    wait_valid(400, cyc, cs_low, rises, ok);
    chk({tag, "_valid_seen"}, 32'(ok), 1);
    chk({tag, "_cs_low_cycles"}, 1 + cs_low, CS_LOW);
    chk({tag, "_sclk_rises"}, rises, 16);
    check_sample(tag, w);
    @(negedge clk_100MHz);
    chk({tag, "_valid_width"}, 32'(ADC_Valid), 0);
    idle_watch({tag, "_idle_after"}, 300);
  endtask

  initial begin
    logic [15:0] words[5];
    logic [15:0] w_abort, w_fresh;
    int cyc, cs_low, rises;
    bit ok;

    // Reset and idle
    repeat (3) @(negedge clk_100MHz);
    Rst_n = 1'b1;
    idle_watch("reset_idle", 20);
    chk("reset_cs_n", 32'(ADC_Cs_n), 1);
    chk("reset_sclk", 32'(ADC_Sclk), 1);
    chk("reset_data", 32'(ADC_Data), 0);
    chk("reset_valid", 32'(ADC_Valid), 0);
    chk("reset_err", 32'(ADC_Frame_Err), 0);
    chk("reset_cnt", 32'(Sample_Cnt), 0);

    run_single("single", 16'h0ABC);
    run_single("lead_err", 16'h8123);
    run_single("rand_single", 16'($urandom));

    // Continuous conversion from a fresh reset
    Rst_n = 1'b0;
    @(negedge clk_100MHz);
    Rst_n = 1'b1;
    exp_cnt = 0;
    words[0] = 16'h0001; words[1] = 16'h0FFF; words[2] = 16'h0800;
    words[3] = 16'($urandom) & 16'h0FFF; words[4] = 16'($urandom);
    for (int i = 0; i < 5; i++) tx_q.push_back(words[i]);
    ADC_En = 1'b1;
    wait_valid(400, cyc, cs_low, rises, ok);
    chk("cont_first_valid", 32'(ok), 1);
    check_sample("cont0", words[0]);
    for (int i = 1; i < 5; i++) begin
      wait_valid(400, cyc, cs_low, rises, ok);
      chk($sformatf("cont%0d_valid_seen", i), 32'(ok), 1);
      chk($sformatf("cont%0d_spacing", i), cyc, FRAME_CYC);
      chk($sformatf("cont%0d_cs_low", i), cs_low, CS_LOW);
      chk($sformatf("cont%0d_rises", i), rises, 16);
      check_sample($sformatf("cont%0d", i), words[i]);
      if (i == 4) ADC_En = 1'b0;
    end
    idle_watch("cont_idle_after", 300);

    // Disable during bit 5
    tx_q.push_back(16'h0555);
    ADC_En = 1'b1;
    wait_rises(5, 200, ok);
    chk("dis_reach_bit5", 32'(ok), 1);
    ADC_En = 1'b0;
    wait_valid(400, cyc, cs_low, rises, ok);
    chk("dis_valid_seen", 32'(ok), 1);
    check_sample("dis", 16'h0555);
    idle_watch("dis_idle_after", 500);

    // Asynchronous reset during bit 8, then a fresh frame
    w_abort = 16'($urandom);
    w_fresh = 16'($urandom) & 16'h0FFF;
    tx_q.push_back(w_abort);
    tx_q.push_back(w_fresh);
    ADC_En = 1'b1;
    wait_rises(8, 200, ok);
    chk("arst_reach_bit8", 32'(ok), 1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_cs_n", 32'(ADC_Cs_n), 1);
    chk("arst_sclk", 32'(ADC_Sclk), 1);
    chk("arst_valid", 32'(ADC_Valid), 0);
    chk("arst_cnt", 32'(Sample_Cnt), 0);
    exp_cnt = 0;
    repeat (3) @(negedge clk_100MHz);
    chk("arst_hold_valid", 32'(ADC_Valid), 0);
    Rst_n = 1'b1;
    wait_valid(400, cyc, cs_low, rises, ok);
    chk("arst_fresh_valid", 32'(ok), 1);
    chk("arst_fresh_rises", rises, 16);
    check_sample("arst_fresh", w_fresh);
    ADC_En = 1'b0;
    repeat (10) @(negedge clk_100MHz);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
